lectura_fecha_rtc: RTL

- Read sequencer upstream of the date-setting block.
- On request, runs a multiplexed address/data bus read burst on the external RTC: day, month, year.
- Range-checks the captured BCD bytes and presents them atomically on `OUT_diaf`/`OUT_mesf`/`OUT_anof`. These feed the date block's `IN_diaf`/`IN_mesf`/`IN_anof`.
- Bus direction control (`AD_oe`) is exported; the tri-state buffer sits at top level.

---
 rtl/lectura_fecha_rtc.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/lectura_fecha_rtc.sv
// Read sequencer for an external RTC on a multiplexed address/data bus: reads day, month, year
// into shadows, range-checks them and commits atomically. Define LECTURA_HORA_EN to also read sec/min/hour.
module lectura_fecha_rtc #(
  parameter int T_FASE = 8
) (
  input  logic       reloj,
  input  logic       resetM,
  input  logic       iniciar,
  input  logic [7:0] AD_in,
  output logic [7:0] AD_out,
  output logic       AD_oe,
  output logic       CS_n,
  output logic       RD_n,
  output logic       WR_n,
  output logic       A_D_n,
  output logic [7:0] OUT_diaf,
  output logic [7:0] OUT_mesf,
  output logic [7:0] OUT_anof,
`ifdef LECTURA_HORA_EN
  output logic [7:0] OUT_seg,
  output logic [7:0] OUT_min,
  output logic [7:0] OUT_hora,
`endif
  output logic       dato_valido,
  output logic       ocupado,
  output logic       error_bcd,
  output logic [2:0] estado
);

`ifdef LECTURA_HORA_EN
  localparam int N = 6;
  localparam logic [7:0] DIR_BASE = 8'h21;
`else
  localparam int N = 3;
  localparam logic [7:0] DIR_BASE = 8'h24;
`endif
  localparam int D  = N - 3;
  localparam int CW = $clog2(T_FASE);
  localparam int IW = $clog2(N);

  typedef enum logic [2:0] {IDLE, ADDR, GAP_A, READ, GAP_R, COMMIT} estado_t;

  estado_t        st;
  logic [CW-1:0]  cnt;
  logic [IW-1:0]  idx;
  logic [7:0]     sh [N];
  logic           fin;
  logic           valido;

  assign estado = st;
  assign fin    = (cnt == CW'(T_FASE - 1));

  // Valid BCD bytes order the same as their decimal values, so plain byte bounds suffice.
  function automatic logic bcd_en_rango(input logic [7:0] b, input logic [7:0] lo, input logic [7:0] hi);
    return (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9) && (b >= lo) && (b <= hi);
  endfunction

  always_comb begin
    valido = bcd_en_rango(sh[D], 8'h01, 8'h31) &&
             bcd_en_rango(sh[D+1], 8'h01, 8'h12) &&
             bcd_en_rango(sh[D+2], 8'h00, 8'h99);
`ifdef LECTURA_HORA_EN
    valido = valido && bcd_en_rango(sh[0], 8'h00, 8'h59) &&
             bcd_en_rango(sh[1], 8'h00, 8'h59) && bcd_en_rango(sh[2], 8'h00, 8'h23);
`endif
  end

  always_ff @(posedge reloj) begin
    if (resetM) begin
      st          <= IDLE;
      cnt         <= '0;
      idx         <= '0;
      for (int i = 0; i < N; i++) sh[i] <= 8'h00;
      AD_out      <= 8'h00;
      AD_oe       <= 1'b0;
      CS_n        <= 1'b1;
      RD_n        <= 1'b1;
      WR_n        <= 1'b1;
      A_D_n       <= 1'b1;
      OUT_diaf    <= 8'h01;
      OUT_mesf    <= 8'h01;
      OUT_anof    <= 8'h00;
`ifdef LECTURA_HORA_EN
      OUT_seg     <= 8'h00;
      OUT_min     <= 8'h00;
      OUT_hora    <= 8'h00;
`endif
      dato_valido <= 1'b0;
      ocupado     <= 1'b0;
      error_bcd   <= 1'b0;
    end else begin
      dato_valido <= 1'b0;
      cnt <= (st == IDLE || st == COMMIT || fin) ? '0 : cnt + CW'(1);
      // Strobes are registered: each transition sets the levels of the phase being entered.
      case (st)
        IDLE: if (iniciar) begin
          st        <= ADDR;
          idx       <= '0;
          error_bcd <= 1'b0;
          ocupado   <= 1'b1;
          CS_n      <= 1'b0;
          WR_n      <= 1'b0;
          A_D_n     <= 1'b0;
          AD_oe     <= 1'b1;
          AD_out    <= DIR_BASE;
        end
        ADDR: if (fin) begin
          st    <= GAP_A;
          CS_n  <= 1'b1;
          WR_n  <= 1'b1;
          A_D_n <= 1'b1;
          AD_oe <= 1'b0;
        end
        GAP_A: if (fin) begin
          st   <= READ;
          CS_n <= 1'b0;
          RD_n <= 1'b0;
        end
        READ: if (fin) begin
          st      <= GAP_R;
          sh[idx] <= AD_in;
          CS_n    <= 1'b1;
          RD_n    <= 1'b1;
        end
        GAP_R: if (fin) begin
          if (idx != IW'(N - 1)) begin
            st     <= ADDR;
            idx    <= idx + IW'(1);
            CS_n   <= 1'b0;
            WR_n   <= 1'b0;
            A_D_n  <= 1'b0;
            AD_oe  <= 1'b1;
            AD_out <= DIR_BASE + 8'(idx) + 8'd1;
          end else begin
            st <= COMMIT;
          end
        end
        COMMIT: begin
          if (valido) begin
            OUT_diaf    <= sh[D];
            OUT_mesf    <= sh[D+1];
            OUT_anof    <= sh[D+2];
`ifdef LECTURA_HORA_EN
            OUT_seg     <= sh[0];
            OUT_min     <= sh[1];
            OUT_hora    <= sh[2];
`endif
            dato_valido <= 1'b1;
          end else begin
            error_bcd <= 1'b1;
          end
          st      <= IDLE;
          ocupado <= 1'b0;
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule
